// File: rtl/hist_acq_sequencer_pkg.sv
// rtl/hist_acq_sequencer_pkg.sv - shared states, default sizes and width helper for the histogram sequencer
package hist_acq_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_ACCUM = 2'd2,
    ST_SWAP  = 2'd3
  } state_e;

  localparam int DATA_NUM_DEF  = 2;
  localparam int PIXEL_NUM_DEF = 200;
  localparam int ACQ_NUM_DEF   = 33333;
  localparam int BIN_AW_DEF    = 8;

  // Counter width for a count that wraps at n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hist_acq_sequencer_frame_counter.sv
// rtl/hist_acq_sequencer_frame_counter.sv - nested timestamp/pixel/acquisition counters for one frame
module hist_frame_counter
  import hist_acq_sequencer_pkg::*;
#(
  parameter int   DATA_NUM  = DATA_NUM_DEF,
  parameter int   PIXEL_NUM = PIXEL_NUM_DEF,
  parameter int   ACQ_NUM   = ACQ_NUM_DEF,
  localparam int  IW        = cnt_w(DATA_NUM),
  localparam int  PW        = cnt_w(PIXEL_NUM),
  localparam int  AW        = cnt_w(ACQ_NUM)
) (
  input  logic          clk_i,
  input  logic          res_i,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [PW-1:0] pixel_idx_o,
  output logic [AW-1:0] acq_idx_o,
  output logic          last_in_frame_o
);

  localparam logic [IW-1:0] IN_MAX  = IW'(DATA_NUM - 1);
  localparam logic [PW-1:0] PIX_MAX = PW'(PIXEL_NUM - 1);
  localparam logic [AW-1:0] ACQ_MAX = AW'(ACQ_NUM - 1);

  logic [IW-1:0] in_q, in_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [AW-1:0] acq_q, acq_d;
  logic          in_wrap, pix_wrap, acq_wrap;

  assign in_wrap  = (in_q == IN_MAX);
  assign pix_wrap = (pix_q == PIX_MAX);
  assign acq_wrap = (acq_q == ACQ_MAX);
  assign last_in_frame_o = inc_i && in_wrap && pix_wrap && acq_wrap;

  always_comb begin
    in_d  = in_q;
    pix_d = pix_q;
    acq_d = acq_q;
    if (clr_i) begin
      in_d  = '0;
      pix_d = '0;
      acq_d = '0;
    end else if (inc_i) begin
      if (in_wrap) begin
        in_d = '0;
        if (pix_wrap) begin
          pix_d = '0;
          acq_d = acq_wrap ? '0 : acq_q + 1'b1;
        end else begin
          pix_d = pix_q + 1'b1;
        end
      end else begin
        in_d = in_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      in_q  <= '0;
      pix_q <= '0;
      acq_q <= '0;
    end else begin
      in_q  <= in_d;
      pix_q <= pix_d;
      acq_q <= acq_d;
    end
  end

  assign pixel_idx_o = pix_q;
  assign acq_idx_o   = acq_q;

endmodule

// File: rtl/hist_acq_sequencer.sv
// rtl/hist_acq_sequencer.sv - clears a histogram bank, gates timestamp increments into it, ping-pongs banks to readout
module hist_acq_sequencer
  import hist_acq_sequencer_pkg::*;
#(
  parameter int  DATA_NUM  = DATA_NUM_DEF,
  parameter int  PIXEL_NUM = PIXEL_NUM_DEF,
  parameter int  ACQ_NUM   = ACQ_NUM_DEF,
  parameter int  BIN_AW    = BIN_AW_DEF,
  localparam int PW        = cnt_w(PIXEL_NUM),
  localparam int AW        = cnt_w(ACQ_NUM)
) (
  input  logic              clk_i,
  input  logic              res_i,
  input  logic              start_i,
  input  logic              ts_valid_i,
  input  logic [BIN_AW-1:0] ts_addr_i,
  output logic              hist_we_o,
  output logic              hist_clr_o,
  output logic [BIN_AW-1:0] hist_addr_o,
  output logic              bank_sel_o,
  output logic [PW-1:0]     pixel_idx_o,
  output logic [AW-1:0]     acq_idx_o,
  output logic              frame_done_o,
  output logic              bank_valid_o,
  output logic              bank_id_o,
  input  logic              bank_ready_i,
  output logic              busy_o,
  output logic              ts_dropped_o
);

  state_e            state_q;
  logic              hist_we_q, hist_clr_q, bank_sel_q, frame_done_q;
  logic              bank_valid_q, bank_id_q, busy_q, ts_dropped_q;
  logic [BIN_AW-1:0] hist_addr_q;
  logic              cnt_inc, last_in_frame;

  assign cnt_inc = (state_q == ST_ACCUM) && ts_valid_i;

  hist_frame_counter #(
    .DATA_NUM  (DATA_NUM),
    .PIXEL_NUM (PIXEL_NUM),
    .ACQ_NUM   (ACQ_NUM)
  ) u_frame_counter (
    .clk_i           (clk_i),
    .res_i           (res_i),
    .inc_i           (cnt_inc),
    .clr_i           (last_in_frame),
    .pixel_idx_o     (pixel_idx_o),
    .acq_idx_o       (acq_idx_o),
    .last_in_frame_o (last_in_frame)
  );

  // In CLEAR the address register doubles as the clear counter.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q      <= ST_IDLE;
      hist_we_q    <= 1'b0;
      hist_clr_q   <= 1'b0;
      hist_addr_q  <= '0;
      bank_sel_q   <= 1'b0;
      frame_done_q <= 1'b0;
      bank_valid_q <= 1'b0;
      bank_id_q    <= 1'b0;
      busy_q       <= 1'b0;
      ts_dropped_q <= 1'b0;
    end else begin
      hist_we_q    <= 1'b0;
      hist_clr_q   <= 1'b0;
      frame_done_q <= 1'b0;
      if (bank_valid_q && bank_ready_i) bank_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q      <= ST_CLEAR;
            busy_q       <= 1'b1;
            hist_we_q    <= 1'b1;
            hist_clr_q   <= 1'b1;
            hist_addr_q  <= '0;
            ts_dropped_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (ts_valid_i) ts_dropped_q <= 1'b1;
          if (hist_addr_q == '1) begin
            state_q <= ST_ACCUM;
          end else begin
            hist_we_q   <= 1'b1;
            hist_clr_q  <= 1'b1;
            hist_addr_q <= hist_addr_q + 1'b1;
          end
        end
        ST_ACCUM: begin
          if (ts_valid_i) begin
            hist_we_q   <= 1'b1;
            hist_addr_q <= ts_addr_i;
            if (last_in_frame) state_q <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          // The registered bank_valid makes a same-cycle handshake still cost one stall cycle.
          if (bank_valid_q) begin
            if (ts_valid_i) ts_dropped_q <= 1'b1;
          end else begin
            bank_valid_q <= 1'b1;
            bank_id_q    <= bank_sel_q;
            bank_sel_q   <= ~bank_sel_q;
            frame_done_q <= 1'b1;
            if (start_i) begin
              state_q      <= ST_CLEAR;
              hist_we_q    <= 1'b1;
              hist_clr_q   <= 1'b1;
              hist_addr_q  <= '0;
              ts_dropped_q <= 1'b0;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign hist_we_o    = hist_we_q;
  assign hist_clr_o   = hist_clr_q;
  assign hist_addr_o  = hist_addr_q;
  assign bank_sel_o   = bank_sel_q;
  assign frame_done_o = frame_done_q;
  assign bank_valid_o = bank_valid_q;
  assign bank_id_o    = bank_id_q;
  assign busy_o       = busy_q;
  assign ts_dropped_o = ts_dropped_q;

endmodule

// File: tb/tb_hist_acq_sequencer.sv
// tb/tb_hist_acq_sequencer.sv - directed and randomized self-checking bench for hist_acq_sequencer
module tb_hist_acq_sequencer;

  localparam int DN = 2, PN = 3, AN = 2, BAW = 3;
  localparam int DEPTH = 1 << BAW;
  localparam int FRAME_TS = DN * PN * AN;
  localparam int M_IDLE = 0, M_CLEAR = 1, M_ACCUM = 2, M_SWAP = 3;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic start = 1'b0, ts_valid = 1'b0, bank_ready = 1'b0;
  logic [BAW-1:0] ts_addr = '0;
  logic hist_we, hist_clr, bank_sel, frame_done, bank_valid, bank_id, busy, ts_dropped;
  logic [BAW-1:0] hist_addr;
  logic [1:0] pixel_idx;
  logic [0:0] acq_idx;

  int n_checks = 0, n_errors = 0;
  bit cmp_en = 1'b0;

  // model of the expected registered outputs
  int m_mode = M_IDLE, m_cpos = 0, m_n = 0, m_addr = 0;
  bit m_we = 0, m_clr = 0, m_sel = 0, m_bv = 0, m_bid = 0, m_fd = 0, m_drop = 0;

  always #5 clk = ~clk;

  hist_acq_sequencer #(
    .DATA_NUM(DN), .PIXEL_NUM(PN), .ACQ_NUM(AN), .BIN_AW(BAW)
  ) dut (
    .clk_i(clk), .res_i(res), .start_i(start), .ts_valid_i(ts_valid), .ts_addr_i(ts_addr),
    .hist_we_o(hist_we), .hist_clr_o(hist_clr), .hist_addr_o(hist_addr), .bank_sel_o(bank_sel),
    .pixel_idx_o(pixel_idx), .acq_idx_o(acq_idx), .frame_done_o(frame_done),
    .bank_valid_o(bank_valid), .bank_id_o(bank_id), .bank_ready_i(bank_ready),
    .busy_o(busy), .ts_dropped_o(ts_dropped)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_enter_clear();
    m_mode = M_CLEAR; m_cpos = 0; m_we = 1; m_clr = 1; m_addr = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit bv_seen;
    if (res) begin
      m_mode = M_IDLE; m_cpos = 0; m_n = 0; m_addr = 0;
      m_we = 0; m_clr = 0; m_sel = 0; m_bv = 0; m_bid = 0; m_fd = 0; m_drop = 0;
      return;
    end
    bv_seen = m_bv;
    m_we = 0; m_clr = 0; m_fd = 0;
    if (m_bv && bank_ready) m_bv = 0;
    case (m_mode)
      M_IDLE: if (start) model_enter_clear();
      M_CLEAR: begin
        if (ts_valid) m_drop = 1;
        if (m_cpos == DEPTH - 1) m_mode = M_ACCUM;
        else begin m_cpos++; m_we = 1; m_clr = 1; m_addr = m_cpos; end
      end
      M_ACCUM: if (ts_valid) begin
        m_we = 1; m_addr = int'(ts_addr); m_n++;
        if (m_n == FRAME_TS) begin m_n = 0; m_mode = M_SWAP; end
      end
      default: begin
        if (bv_seen) begin
          if (ts_valid) m_drop = 1;
        end else begin
          m_bv = 1; m_bid = m_sel; m_sel = !m_sel; m_fd = 1;
          if (start) model_enter_clear();
          else m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or posedge res);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("we", hist_we, m_we);
      if (m_we) begin
        chk("clr", hist_clr, m_clr);
        chk("addr", hist_addr, m_addr);
      end
      chk("bank_sel", bank_sel, m_sel);
      chk("pixel_idx", pixel_idx, (m_n / DN) % PN);
      chk("acq_idx", acq_idx, m_n / (DN * PN));
      chk("frame_done", frame_done, m_fd);
      chk("bank_valid", bank_valid, m_bv);
      if (m_bv) chk("bank_id", bank_id, m_bid);
      chk("busy", busy, (m_mode != M_IDLE) ? 1 : 0);
      chk("ts_dropped", ts_dropped, m_drop);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed_frame();
    for (int i = 0; i < FRAME_TS; i++) begin
      ts_valid = 1'b1;
      ts_addr = BAW'($urandom_range(0, DEPTH - 1));
      tick();
    end
    ts_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, hist_we, 0);
    chk({tag, "_clr"}, hist_clr, 0);
    chk({tag, "_addr"}, hist_addr, 0);
    chk({tag, "_sel"}, bank_sel, 0);
    chk({tag, "_pix"}, pixel_idx, 0);
    chk({tag, "_acq"}, acq_idx, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_bv"}, bank_valid, 0);
    chk({tag, "_bid"}, bank_id, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_drop"}, ts_dropped, 0);
  endtask

  int pix_seq[12] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    res = 1'b0;
    cmp_en = 1'b1;

    // 1: clear sweep
    start = 1'b1;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      chk("t1_we", hist_we, 1); chk("t1_clr", hist_clr, 1);
      chk("t1_addr", hist_addr, i); chk("t1_busy", busy, 1);
      tick();
    end
    chk("t1_accum_we", hist_we, 0);

    // 2: one full frame back-to-back
    for (int i = 0; i < 12; i++) begin
      ts_valid = 1'b1;
      ts_addr = BAW'(i % 8);
      chk("t2_pixel", pixel_idx, pix_seq[i]);
      chk("t2_acq", acq_idx, (i < 6) ? 0 : 1);
      tick();
      chk("t2_we", hist_we, 1); chk("t2_clr", hist_clr, 0); chk("t2_addr", hist_addr, i % 8);
    end
    ts_valid = 1'b0;
    chk("t2_fd_early", frame_done, 0);
    tick();
    chk("t2_fd", frame_done, 1); chk("t2_bv", bank_valid, 1);
    chk("t2_bid", bank_id, 0); chk("t2_sel", bank_sel, 1);
    chk("t2_model_bid", m_bid, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_clr_addr", hist_addr, i); chk("t2_clr_flag", hist_clr, 1);
      tick();
    end

    // 3: swap stall while readout holds the previous bank
    feed_frame();
    ts_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t3_stall_we", hist_we, 0); chk("t3_stall_bv", bank_valid, 1);
      chk("t3_drop", ts_dropped, 1); chk("t3_stall_fd", frame_done, 0);
    end
    ts_valid = 1'b0;
    bank_ready = 1'b1;
    tick();
    chk("t3_bv_fall", bank_valid, 0); chk("t3_no_fd", frame_done, 0);
    bank_ready = 1'b0;
    tick();
    chk("t3_fd", frame_done, 1); chk("t3_bid", bank_id, 1);
    chk("t3_sel", bank_sel, 0); chk("t3_drop_clr", ts_dropped, 0);

    // 4: timestamp during clear is dropped, address sweep continues
    bank_ready = 1'b1;
    tick();
    chk("t4_consumed", bank_valid, 0);
    bank_ready = 1'b0;
    tick();
    chk("t4_addr2", hist_addr, 2);
    ts_valid = 1'b1;
    tick();
    ts_valid = 1'b0;
    chk("t4_addr3", hist_addr, 3); chk("t4_clr", hist_clr, 1); chk("t4_drop", ts_dropped, 1);
    for (int a = 4; a < DEPTH; a++) begin
      tick();
      chk("t4_addr", hist_addr, a);
    end
    tick();
    feed_frame();
    tick();
    chk("t4_fd", frame_done, 1); chk("t4_bid", bank_id, 0); chk("t4_drop_clr", ts_dropped, 0);

    // 5: asynchronous reset mid-accumulation
    repeat (DEPTH) tick();
    for (int i = 0; i < 4; i++) begin
      ts_valid = 1'b1; ts_addr = BAW'(i); tick();
    end
    ts_valid = 1'b0;
    chk("t5_pixel", pixel_idx, 2);
    #2;
    res = 1'b1;
    #1;
    chk_all_zero("t5_async");
    tick();
    res = 1'b0;
    tick();
    chk("t5_we", hist_we, 1); chk("t5_addr", hist_addr, 0);
    chk("t5_acq", acq_idx, 0); chk("t5_sel", bank_sel, 0);

    // 6: start dropped mid-frame, frame still completes, then idle
    repeat (DEPTH) tick();
    start = 1'b0;
    feed_frame();
    tick();
    chk("t6_fd", frame_done, 1); chk("t6_bid", bank_id, 0); chk("t6_busy", busy, 0);
    ts_valid = 1'b1;
    repeat (3) begin
      tick();
      chk("t6_idle_we", hist_we, 0); chk("t6_idle_drop", ts_dropped, 0);
    end
    ts_valid = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 9) != 0);
      ts_valid = ($urandom_range(0, 3) != 0);
      ts_addr = BAW'($urandom_range(0, DEPTH - 1));
      bank_ready = ($urandom_range(0, 2) == 0);
      if (c % 1000 == 999) res = 1'b1;
      tick();
      res = 1'b0;
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hist_acq_sequencer.md
Name: hist_acq_sequencer

Overview:
Sequences one histogram-building frame for the SiFH histogram datapath.
- Clears the active histogram bank, then gates timestamp writes into it.
- Tracks nested input/pixel/acquisition counts.
- Ping-pongs between two banks, handing each completed bank to readout over a valid/ready handshake.
- Sits between the TDC timestamp stream and the histogram BRAM write port; the readout/peak-detect logic consumes the finished bank.

Parameters:
DATA_NUM, 2, timestamps per pixel per acquisition
PIXEL_NUM, 200, pixels per acquisition
ACQ_NUM, 33333, acquisitions per frame
BIN_AW, 8, histogram bin address width; bank depth = 2^BIN_AW

Ports:
clk  in  1  clock
res  in  1  asynchronous reset, active-high
start  in  1  level enable; sampled only in IDLE and SWAP
ts_valid  in  1  timestamp strobe
ts_addr  in  BIN_AW  bin address of timestamp
hist_we  out  1  histogram write/increment enable
hist_clr  out  1  1 = write zero (clear), 0 = increment
hist_addr  out  BIN_AW  histogram bin address
bank_sel  out  1  bank currently being built
pixel_idx  out  clog2(PIXEL_NUM)  current pixel
acq_idx  out  clog2(ACQ_NUM)  current acquisition
frame_done  out  1  one-cycle pulse at frame completion
bank_valid  out  1  completed bank available
bank_id  out  1  completed bank number; stable while bank_valid=1
bank_ready  in  1  readout accepts bank
busy  out  1  state != IDLE
ts_dropped  out  1  sticky: a ts_valid was not written this frame

Behaviour:
- Reset (async, res=1): state IDLE; all outputs 0, including bank_sel, bank_valid, bank_id and ts_dropped; all counters 0. Takes effect immediately, mid-operation included; a pending bank_valid is discarded.
- States: IDLE, CLEAR, ACCUM, SWAP. All outputs registered.
- IDLE: start=1 -> CLEAR. ts_valid is ignored and does not set ts_dropped.
- CLEAR:
  - Per cycle: hist_we=1, hist_clr=1, hist_addr=clr_cnt, with clr_cnt counting 0..2^BIN_AW-1.
  - Exactly 2^BIN_AW cycles, then -> ACCUM.
  - ts_valid here is dropped and sets ts_dropped.
  - ts_dropped is cleared on CLEAR entry.
- ACCUM:
  - ts_valid=1 produces hist_we=1, hist_clr=0, hist_addr=ts_addr on the next cycle (latency 1). Back-to-back ts_valid is supported every cycle.
  - in_cnt increments per accepted timestamp. At DATA_NUM-1 it wraps to 0 and pixel_idx increments.
  - pixel_idx wraps at PIXEL_NUM-1 and acq_idx increments.
  - The accepted timestamp with in_cnt=DATA_NUM-1, pixel_idx=PIXEL_NUM-1 and acq_idx=ACQ_NUM-1 is the last one of the frame: it is written, then -> SWAP.
  - Counters reset to 0 on SWAP entry.
  - start deassertion in ACCUM is ignored; the frame always completes.
- SWAP:
  - If bank_valid=0:
    - Set bank_valid=1 and bank_id=bank_sel; toggle bank_sel; pulse frame_done for one cycle.
    - Then -> CLEAR if start=1, else IDLE.
  - If bank_valid=1 (previous bank not yet consumed): stall in SWAP. ts_valid is dropped and sets ts_dropped.
- Handshake: the transfer completes in the cycle where bank_valid and bank_ready are both 1; bank_valid falls the next cycle. bank_ready while bank_valid=0 has no effect.
  - If a handshake completes in the same cycle SWAP needs to post a bank, SWAP still stalls one cycle. No combinational ready->valid path.
- Widths: counters are sized clog2 of their limit (minimum 1). No arithmetic overflow is possible since every counter wraps at an explicit limit.

Decomposition:
- Shared package/header (parametersSiFH.vh family): state encodings, DATA_NUM, PIXEL_NUM, ACQ_NUM and BIN_AW defaults, clog2 width macros.
- Sub-module hist_frame_counter: nested in/pixel/acq counters. It takes an inc and clr input and outputs pixel_idx, acq_idx and a last_in_frame flag (combinational on the current counts and inc). It is reused by the readout side.

Test Plan:
(Run with DATA_NUM=2, PIXEL_NUM=3, ACQ_NUM=2, BIN_AW=3.)
1. Release res, start=1 -> 8 cycles with hist_we=1, hist_clr=1, hist_addr 0..7; busy=1; then ACCUM with no writes.
2. 12 consecutive ts_valid with ts_addr=i%8 -> 12 writes with hist_clr=0, each one cycle after its input; pixel_idx sequence 0,0,1,1,2,2,0,0,1,1,2,2; acq_idx 0 for 6 timestamps then 1. After the 12th: frame_done pulse, bank_valid=1, bank_id=0, bank_sel=1, then an 8-cycle CLEAR.
3. bank_ready=0 through frame 2 -> SWAP stall; 3 ts_valid during the stall produce no hist_we and set ts_dropped=1. Then bank_ready=1 -> bank_valid falls. Next cycle posts bank_id=1, bank_sel=0, frame_done.
4. ts_valid on the 3rd CLEAR cycle -> hist_addr continues 3,4,...; no increment write; ts_dropped=1, cleared at the next CLEAR entry.
5. res=1 mid-ACCUM (pixel_idx=2) -> all outputs 0 asynchronously. After release with start=1, CLEAR restarts at addr 0 with acq_idx=0 and bank_sel=0.
6. start=0 during frame 1 ACCUM -> frame still completes; SWAP posts bank 0, goes to IDLE, busy=0; later ts_valid has no effect.
